// File: rtl/reg_load_sched.sv
// Write-port scheduler: two requesters share one write path into a bank of load-enabled registers.
// Optional macro REG_LOAD_SCHED_FIXED_PRIO_EN: on a tie requester A always wins (default is round-robin).
module reg_load_sched #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    localparam int NREG  = 2**ADDR_W
) (
    input  logic              C,
    input  logic              nR,
    input  logic              reqA,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [DATA_W-1:0] dataA,
    output logic              ackA,
    input  logic              reqB,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] dataB,
    output logic              ackB,
    output logic [NREG-1:0]   L,
    output logic [DATA_W-1:0] D,
    output logic              busy,
    output logic              last_grant
);

    // state | meaning
    // IDLE  | sample requests, arbitrate, latch winner's addr/data
    // LOAD  | one-hot load enable on L for one cycle, D carries latched data
    // ACK   | L cleared, winner's ack pulses for one cycle
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [NREG-1:0]     l_q, l_d;
    logic                winner_q, winner_d;
    logic                last_grant_q, last_grant_d;
    logic                ack_a_q, ack_a_d;
    logic                ack_b_q, ack_b_d;
    logic                busy_q, busy_d;

    logic                tie_pick_b;
    logic                win_b;
    logic [ADDR_W-1:0]   sel_addr;

`ifdef REG_LOAD_SCHED_FIXED_PRIO_EN
    assign tie_pick_b = 1'b0;
`else
    assign tie_pick_b = ~last_grant_q;
`endif

    assign win_b    = reqB & (~reqA | tie_pick_b);
    assign sel_addr = win_b ? addrB : addrA;

    always_comb begin
        state_d      = state_q;
        data_d       = data_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        l_d          = '0;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (reqA || reqB) begin
                    winner_d     = win_b;
                    last_grant_d = win_b;
                    data_d       = win_b ? dataB : dataA;
                    // register 0 is hardwired zero: the write is scheduled but never enabled
                    if (sel_addr != '0) begin
                        l_d[sel_addr] = 1'b1;
                    end
                    state_d = LOAD;
                end
            end
            LOAD: begin
                ack_a_d = ~winner_q;
                ack_b_d = winner_q;
                state_d = ACK;
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge C) begin
        if (!nR) begin
            state_q      <= IDLE;
            data_q       <= '0;
            l_q          <= '0;
            winner_q     <= 1'b0;
            last_grant_q <= 1'b1;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            data_q       <= data_d;
            l_q          <= l_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            busy_q       <= busy_d;
        end
    end

    assign L          = l_q;
    assign D          = data_q;
    assign ackA       = ack_a_q;
    assign ackB       = ack_b_q;
    assign busy       = busy_q;
    assign last_grant = last_grant_q;

endmodule

// File: doc/reg_load_sched.md
# reg_load_sched

Write-port scheduler for the register bank built from load-enabled 1-bit register cells. Two requesters (A, B) compete for the single write path. The block arbitrates round-robin, latches the winner's address and data, and drives the bank's shared data bus plus a one-hot per-register load enable for exactly one cycle. It then acknowledges the winning requester.

## Interface
- DATA_W, 32, width of the register bank word and of the D bus
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers
- C  input  1  clock, rising-edge
- nR  input  1  reset, synchronous, active-low
- reqA  input  1  requester A write request, level, held until ackA
- addrA  input  ADDR_W  requester A target register
- dataA  input  DATA_W  requester A write data
- ackA  output  1  one-cycle completion pulse to A
- reqB / addrB / dataB / ackB  same as A, for requester B
- L  output  NREG  one-hot load enables to the bank (L[i] drives register i)
- D  output  DATA_W  shared write data bus to the bank
- busy  output  1  high whenever state != IDLE
- last_grant  output  1  0 = A won last arbitration, 1 = B

## Operation
- Reset is synchronous and active-low: nR sampled low at a rising edge of C.
- Reset values: state=IDLE, L=0, D=0, ackA=0, ackB=0, busy=0, last_grant=1, so A wins the first tie.
- Registers: state, latched addr, latched data, winner, last_grant, ackA, ackB. All outputs are registered.
- FSM states: IDLE, LOAD, ACK.
- **IDLE:**
  - No req → stay in IDLE.
  - Exactly one req → that requester wins.
  - Both req → the requester != last_grant wins.
  - On a win: latch addr/data, last_grant ← winner, go to LOAD.
- **LOAD:**
  - D = latched data.
  - L[latched addr] = 1 for this single cycle; all other bits of L are 0.
  - Go to ACK.
- **ACK:**
  - L = 0, D holds its value.
  - Winner's ack = 1 for this single cycle; the other ack stays 0.
  - Go to IDLE.
- Address 0 is the hardwired-zero register. A write to addr 0 still passes through LOAD and ACK, but L stays all-zero, and the requester is still acknowledged.
- Requests arriving while busy are not sampled. They wait, with req held, until the next IDLE.
- The losing requester keeps req high and wins the next arbitration.

## Timing
- Latency: req sampled high in IDLE at edge k → L pulse during cycle k+1 → ack during cycle k+2 → IDLE at cycle k+3.
- Throughput: one write per 3 cycles. Back-to-back alternation A/B is possible with no idle gap beyond IDLE.
- Handshake rules:
  - A requester must deassert req at the edge that ends its ack cycle.
  - A req still high when IDLE is sampled is treated as a new request.
  - addr/data must be stable from req rise until the edge that leaves IDLE. They are don't-care afterwards.
- Reset mid-operation:
  - nR low during LOAD → L=0 from the next cycle. The transaction is dropped and no ack is issued.
  - nR low during ACK → the pending ack is cleared.
  - In both cases the requester must re-request after reset.
- A requester never receives two acks for one req phase.
- L is never multi-hot.

## Configuration
- REG_LOAD_SCHED_FIXED_PRIO_EN:
  - Defined → on a tie, A always wins. last_grant still updates but is ignored by arbitration.
  - Undefined (default) → round-robin as described under Operation.

## Test plan
- Reset: nR=0 for 2 cycles with reqA=reqB=1 → L=0, D=0, ackA=ackB=0, busy=0, last_grant=1. Release nR → A wins first.
- Single write: reqA=1, addrA=5, dataA=32'hDEADBEEF → next cycle L=32'h0000_0020 and D=32'hDEADBEEF, following cycle ackA=1, then busy=0.
- Contention: reqA=reqB=1 held, addrA=3, addrB=7 → grants alternate A,B,A,B, one L pulse each, 3 cycles apart. With REG_LOAD_SCHED_FIXED_PRIO_EN → A,A,A while reqA held.
- Zero register: reqB=1, addrB=0, dataB=32'h1 → L stays 0 throughout, ackB=1 on cycle 2, busy drops on cycle 3.
- Reset mid-LOAD: reqA=1, addrA=9; assert nR=0 in the LOAD cycle → L=0 next cycle, ackA never pulses, state=IDLE.
- Stall: reqB rises while A's transaction is in LOAD → B is not granted until IDLE; B's L pulse follows A's by exactly 3 cycles.
